// File: rtl/exibe_onehot_7seg.sv
// ============================================================================
// exibe_onehot_7seg : registered one-hot to single hex digit 7-segment driver
//                     with empty/error classification, blanking and blink.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exibe_onehot_7seg #(
  parameter int N          = 16,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] onehot,
  input  logic         carrega,
  input  logic         pisca,
  input  logic         apaga,
  output logic [6:0]   display,
  output logic [3:0]   indice,
  output logic         valido,
  output logic         erro
);

  localparam int          CW        = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0]  C_OFF_AL  = 7'b1111111;
  localparam logic [6:0]  C_DASH_AL = 7'b0111111;
  localparam logic [6:0]  C_BLANK   = (ACTIVE_LOW != 0) ? C_OFF_AL : ~C_OFF_AL;

  typedef enum logic [1:0] {
    VAZIO  = 2'd0,
    MOSTRA = 2'd1,
    ERRO   = 2'd2
  } state_t;

  state_t          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic            r_phase, w_phase_d;
  logic [3:0]      w_indice_d;
  logic            w_valido_d, w_erro_d;
  logic [6:0]      w_seg_al, w_display_d;
  logic [4:0]      w_ones;
  logic [3:0]      w_pos;

  // Active-low glyphs, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    w_ones = '0;
    w_pos  = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        w_ones = w_ones + 5'd1;
        w_pos  = 4'(i);
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_indice_d = indice;
    w_valido_d = valido;
    w_erro_d   = erro;
    if (carrega) begin
      if (w_ones == 5'd0) begin
        w_state_d  = VAZIO;
        w_indice_d = 4'd0;
        w_valido_d = 1'b0;
        w_erro_d   = 1'b0;
      end else if (w_ones == 5'd1) begin
        w_state_d  = MOSTRA;
        w_indice_d = w_pos;
        w_valido_d = 1'b1;
        w_erro_d   = 1'b0;
      end else begin
        w_state_d  = ERRO;
        w_indice_d = 4'd0;
        w_valido_d = 1'b0;
        w_erro_d   = 1'b1;
      end
    end

    // Blink runs only while enabled; disabling parks it at the start of ON.
    w_cnt_d   = '0;
    w_phase_d = 1'b1;
    if (pisca) begin
      if (r_cnt == C_CNT_MAX) begin
        w_cnt_d   = '0;
        w_phase_d = ~r_phase;
      end else begin
        w_cnt_d   = r_cnt + CW'(1);
        w_phase_d = r_phase;
      end
    end

    case (w_state_d)
      MOSTRA:  w_seg_al = glyph(w_indice_d);
      ERRO:    w_seg_al = C_DASH_AL;
      default: w_seg_al = C_OFF_AL;
    endcase
    if (apaga || !w_phase_d) begin
      w_seg_al = C_OFF_AL;
    end
    w_display_d = (ACTIVE_LOW != 0) ? w_seg_al : ~w_seg_al;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= VAZIO;
      indice  <= 4'd0;
      valido  <= 1'b0;
      erro    <= 1'b0;
      display <= C_BLANK;
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else begin
      r_state <= w_state_d;
      indice  <= w_indice_d;
      valido  <= w_valido_d;
      erro    <= w_erro_d;
      display <= w_display_d;
      r_cnt   <= w_cnt_d;
      r_phase <= w_phase_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exibe_onehot_7seg.sv
// ============================================================================
// tb_exibe_onehot_7seg : directed self-checking bench for exibe_onehot_7seg.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exibe_onehot_7seg;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] onehot = '0;
  logic        carrega = 1'b0;
  logic        pisca = 1'b0;
  logic        apaga = 1'b0;
  logic [6:0]  display;
  logic [3:0]  indice;
  logic        valido;
  logic        erro;

  logic [7:0]  onehot8 = '0;
  logic        carrega8 = 1'b0;
  logic [6:0]  display8;
  logic [3:0]  indice8;
  logic        valido8;
  logic        erro8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  exibe_onehot_7seg #(.N(16), .BLINK_DIV(4), .ACTIVE_LOW(1)) dut (
    .clock(clock), .reset(reset), .onehot(onehot), .carrega(carrega),
    .pisca(pisca), .apaga(apaga), .display(display), .indice(indice),
    .valido(valido), .erro(erro)
  );

  exibe_onehot_7seg #(.N(8), .BLINK_DIV(4), .ACTIVE_LOW(0)) dut_inv (
    .clock(clock), .reset(reset), .onehot(onehot8), .carrega(carrega8),
    .pisca(1'b0), .apaga(1'b0), .display(display8), .indice(indice8),
    .valido(valido8), .erro(erro8)
  );

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  function automatic logic [6:0] exp_glyph(input int d);
    case (d)
      0: exp_glyph = 7'b1000000;   1: exp_glyph = 7'b1111001;
      2: exp_glyph = 7'b0100100;   3: exp_glyph = 7'b0110000;
      4: exp_glyph = 7'b0011001;   5: exp_glyph = 7'b0010010;
      6: exp_glyph = 7'b0000010;   7: exp_glyph = 7'b1111000;
      8: exp_glyph = 7'b0000000;   9: exp_glyph = 7'b0010000;
      10: exp_glyph = 7'b0001000;  11: exp_glyph = 7'b0000011;
      12: exp_glyph = 7'b1000110;  13: exp_glyph = 7'b0100001;
      14: exp_glyph = 7'b0000110;  default: exp_glyph = 7'b0001110;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    @(negedge clock);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_display", 16'(display), 16'(BLANK));
    check("rst_indice",  16'(indice),  16'd0);
    check("rst_valido",  16'(valido),  16'd0);
    check("rst_erro",    16'(erro),    16'd0);
    check("rst_display_inv", 16'(display8), 16'h0000);

    // Every single-bit position.
    for (int p = 0; p < 16; p++) begin
      onehot  = 16'd1 << p;
      carrega = 1'b1;
      tick();
      check($sformatf("pos%0d_indice", p),  16'(indice),  16'(p));
      check($sformatf("pos%0d_valido", p),  16'(valido),  16'd1);
      check($sformatf("pos%0d_erro", p),    16'(erro),    16'd0);
      check($sformatf("pos%0d_display", p), 16'(display), 16'(exp_glyph(p)));
    end

    // Empty, then multi-bit error.
    onehot = 16'h0000;
    tick();
    check("empty_display", 16'(display), 16'(BLANK));
    check("empty_valido",  16'(valido),  16'd0);
    check("empty_erro",    16'(erro),    16'd0);
    onehot = 16'h0030;
    tick();
    check("err_display", 16'(display), 16'(DASH));
    check("err_erro",    16'(erro),    16'd1);
    check("err_indice",  16'(indice),  16'd0);
    check("err_valido",  16'(valido),  16'd0);

    // Hold: carrega low ignores the input.
    carrega = 1'b0;
    onehot  = 16'h0001;
    tick();
    check("hold_display", 16'(display), 16'(DASH));

    // Blink with BLINK_DIV=4 on digit 3.
    onehot  = 16'h0008;
    carrega = 1'b1;
    tick();
    carrega = 1'b0;
    check("blink_pre", 16'(display), 16'(7'b0110000));
    pisca = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("blink_k%0d", k), 16'(display),
            ((k / 4) % 2 == 0) ? 16'(7'b0110000) : 16'(BLANK));
    end
    pisca = 1'b0;
    tick();
    check("blink_drop", 16'(display), 16'(7'b0110000));
    tick();
    tick();
    check("blink_held", 16'(display), 16'(7'b0110000));

    // Blanking while loading.
    apaga   = 1'b1;
    onehot  = 16'h0100;
    carrega = 1'b1;
    tick();
    carrega = 1'b0;
    check("apaga_display", 16'(display), 16'(BLANK));
    check("apaga_indice",  16'(indice),  16'd8);
    check("apaga_valido",  16'(valido),  16'd1);
    tick();
    check("apaga_hold", 16'(display), 16'(BLANK));
    apaga = 1'b0;
    tick();
    check("apaga_release", 16'(display), 16'(7'b0000000));

    // Reset during the OFF half-period of an error display.
    onehot  = 16'h0030;
    carrega = 1'b1;
    tick();
    carrega = 1'b0;
    pisca   = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    check("errblink_off", 16'(display), 16'(BLANK));
    check("errblink_erro", 16'(erro), 16'd1);
    reset   = 1'b1;
    onehot  = 16'h0004;
    carrega = 1'b1;
    tick();
    reset   = 1'b0;
    carrega = 1'b0;
    check("rst2_display", 16'(display), 16'(BLANK));
    check("rst2_erro",    16'(erro),    16'd0);
    check("rst2_indice",  16'(indice),  16'd0);
    // Phase must be ON again: a load with pisca still high shows at once.
    onehot  = 16'h0002;
    carrega = 1'b1;
    tick();
    carrega = 1'b0;
    check("rst2_phase_on", 16'(display), 16'(7'b1111001));
    pisca = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("steady_k%0d", k), 16'(display), 16'(7'b1111001));
    end

    // Inverted polarity, N=8.
    onehot8  = 8'h80;
    carrega8 = 1'b1;
    tick();
    carrega8 = 1'b0;
    check("inv_display", 16'(display8), 16'(7'b0000111));
    check("inv_indice",  16'(indice8),  16'd7);
    check("inv_valido",  16'(valido8),  16'd1);
    onehot8  = 8'h00;
    carrega8 = 1'b1;
    tick();
    carrega8 = 1'b0;
    check("inv_blank", 16'(display8), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exibe_onehot_7seg.md
Name: exibe_onehot_7seg

Overview:
- Registered, parametrised successor of the one-hot-to-7-segment decoder used on the DE0-CV displays.
- Accepts an N-bit one-hot position vector (N up to 16), captures it on a load strobe and drives one hex digit (0..F) showing the index of the set bit.
- Non-one-hot inputs are classified as empty or error and shown distinctly.
- Adds blanking and blink modes for game feedback: highlighting the current position and flagging a wrong move in the memory-challenge game.

Parameters:
- N, 16, width of one-hot input; legal range 2..16.
- BLINK_DIV, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz); minimum 2.
- ACTIVE_LOW, 1, 1 = segment on when bit is 0 (DE0-CV); 0 = inverted polarity.

Ports:
- clock, in, 1, system clock; all state changes on rising edge.
- reset, in, 1, synchronous, active-high reset.
- onehot, in, N, position vector; sampled only when carrega=1.
- carrega, in, 1, load strobe; one-cycle pulse or held high.
- pisca, in, 1, blink enable, level-sensitive.
- apaga, in, 1, force display blank, level-sensitive; captured state is kept.
- display, out, 7, segments; bit 6 = segment g ... bit 0 = segment a.
- indice, out, 4, binary index of the captured set bit.
- valido, out, 1, captured value was exactly one-hot.
- erro, out, 1, captured value had more than one bit set.

Behaviour:
- Reset (synchronous, active-high):
  - State = VAZIO; indice=0, valido=0, erro=0; display=blank.
  - Blink counter = 0; blink phase = ON.
- Blank pattern is all segments off: 1111111 when ACTIVE_LOW=1, 0000000 when ACTIVE_LOW=0.
- States:
  - VAZIO: nothing shown.
  - MOSTRA: shows the index digit.
  - ERRO: shows dash, segment g only (0111111 active-low).
- Transitions occur only on edges where carrega=1. The captured onehot value selects the next state:
  - Zero bits set -> VAZIO; valido=0, erro=0, indice=0.
  - Exactly one bit set at position p -> MOSTRA; valido=1, erro=0, indice=p.
  - Two or more bits set -> ERRO; valido=0, erro=1, indice=0.
  - Any state may move to any state. carrega=0 holds the current state.
- Digit glyphs (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Indices 0..7 must match the existing 8-bit decoder exactly.
- Latency: carrega high at edge k -> indice, valido, erro and display all reflect the new value after edge k. All outputs are registered; display is computed from next-state values.
- Blink:
  - When pisca=1, the counter counts 0..BLINK_DIV-1, then wraps to 0 and toggles phase.
  - When pisca=0, the counter is held at 0 and phase is forced ON.
  - A rising pisca therefore always starts with a full ON half-period.
  - With pisca=1 and phase OFF, display is blank in states MOSTRA and ERRO. VAZIO is blank regardless.
  - carrega does not restart the counter or phase; the new glyph appears in whatever phase is current.
- apaga=1 forces display blank on the next edge. It has priority over blink and glyph.
  - indice, valido and erro keep updating normally, and the blink counter keeps running.
  - On release, the current glyph and phase reappear after one edge.
- Simultaneous events:
  - carrega with apaga: the load is captured; display stays blank.
  - carrega with reset: reset wins.
- Reset mid-blink or mid-error returns everything to reset values on that edge.

Test Plan:
- Reset, then load each single-bit value 1<<p for p=0..15 with N=16 -> one cycle later indice=p, valido=1, erro=0, display = glyph table entry p (e.g. p=10 -> 0001000).
- Load 0x0000 -> VAZIO, display=1111111, valido=0, erro=0. Then load 0x0030 -> ERRO, display=0111111, erro=1, indice=0.
- BLINK_DIV=4: load 0x0008, then raise pisca -> display 0110000 for 4 cycles, 1111111 for 4 cycles, repeating. Drop pisca -> 0110000 on the next edge, held.
- Hold apaga=1 while loading 0x0100 -> display stays 1111111 while indice=8 and valido=1. Release apaga -> display=0000000 after one edge.
- Assert reset during the blink OFF phase in ERRO -> next edge: display blank, erro=0, phase ON. The following load of 0x0002 shows 1111001 steadily while pisca=0.
- ACTIVE_LOW=0, N=8: load 0x80 -> display=0000111 (the inverted glyph for 7); indice=7.
